// File: rtl/alu_seq.sv
// Multi-cycle accumulator ALU with a start/done handshake and registered result/flags.
// Six ops finish on the accept edge. Multiply and shift-left iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WIDTH-1:0]    dataInACC,
  input  logic [WIDTH-1:0]    dataIn,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]    dataOut,
  output logic                zero,
  output logic                carry,
  output logic                busy,
  output logic                done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_BNZ  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLTS = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]        add_full;
  logic [WIDTH:0]        sub_full;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [CNT_W-1:0]      shamt;
  logic [WIDTH-1:0]      imm_result;
  logic                  imm_carry;
  logic [WIDTH-1:0]      mul_sum;
  logic [WIDTH-1:0]      iter_result;

  assign add_full = {1'b0, dataInACC} + {1'b0, dataIn};
  assign sub_full = {1'b0, dataInACC} - {1'b0, dataIn};
  // pc+1 wraps inside PC_WIDTH bits before it is zero-extended
  assign pc_inc   = pc + PC_WIDTH'(1);
  assign shamt    = CNT_W'(dataIn % WIDTH_V);

  always_comb begin
    imm_result = '0;
    imm_carry  = 1'b0;
    case (op)
      OP_ADD: begin
        imm_result = add_full[WIDTH-1:0];
        imm_carry  = add_full[WIDTH];
      end
      OP_NAND: imm_result = ~(dataInACC & dataIn);
      OP_BNZ:  imm_result = (dataInACC == '0) ? WIDTH'(pc_inc) : dataIn;
      OP_SLTU: imm_result = WIDTH'(dataInACC < dataIn);
      OP_SUB: begin
        imm_result = sub_full[WIDTH-1:0];
        imm_carry  = sub_full[WIDTH];
      end
      OP_SLTS: imm_result = WIDTH'($signed(dataInACC) < $signed(dataIn));
      OP_SHL:  imm_result = dataInACC;
      default: imm_result = '0;
    endcase
  end

  // Shift-add: opa is the shifted multiplicand, opb's low bit is the current multiplier bit
  assign mul_sum     = acc + (opb[0] ? opa : '0);
  assign iter_result = (op_lat == OP_MUL) ? mul_sum : (opa << 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_lat  <= '0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      cnt     <= '0;
      dataOut <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_lat <= op;
            opa    <= dataInACC;
            opb    <= dataIn;
            if (op == OP_MUL) begin
              acc   <= '0;
              cnt   <= CNT_FULL;
              state <= EXEC;
            end else if (op == OP_SHL && shamt != '0) begin
              cnt   <= shamt;
              state <= EXEC;
            end else begin
              dataOut <= imm_result;
              zero    <= (imm_result == '0);
              carry   <= imm_carry;
              state   <= DONE;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_ONE;
          opa <= opa << 1;
          if (op_lat == OP_MUL) begin
            acc <= mul_sum;
            opb <= opb >> 1;
          end
          if (cnt == CNT_ONE) begin
            dataOut <= iter_result;
            zero    <= (iter_result == '0);
            carry   <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: results, flags, latency, handshake and reset abort.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] dataInACC;
  logic [7:0] dataIn;
  logic [7:0] pc;
  logic [7:0] dataOut;
  logic       zero;
  logic       carry;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(8), .PC_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .dataInACC (dataInACC),
    .dataIn    (dataIn),
    .pc        (pc),
    .dataOut   (dataOut),
    .zero      (zero),
    .carry     (carry),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure edges from accept to done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] p, input logic [7:0] exp_d,
                        input logic exp_z, input logic exp_c, input int exp_lat, input bit poke);
    int lat;
    int extra;
    logic all_busy;
    @(negedge clk);
    op = o; dataInACC = a; dataIn = b; pc = p; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; dataInACC = ~a; dataIn = ~b; pc = ~p;
    @(negedge clk);
    lat = 0;
    all_busy = busy;
    while (!done && lat < 40) begin
      if (poke) start = (lat == 2);
      @(negedge clk);
      lat++;
      all_busy = all_busy & busy;
    end
    start = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " dataOut"}, 32'(dataOut), 32'(exp_d));
    check({tag, " zero"}, 32'(zero), 32'(exp_z));
    check({tag, " carry"}, 32'(carry), 32'(exp_c));
    check({tag, " busy during op"}, 32'(all_busy), 32'd1);
    @(negedge clk);
    check({tag, " done width"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " hold"}, 32'(dataOut), 32'(exp_d));
    if (poke) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        extra += int'(done);
      end
      check({tag, " no extra done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    logic [7:0] pat;
    reset = 1'b1; start = 1'b0; op = '0; dataInACC = '0; dataIn = '0; pc = '0;
    #12;
    check("reset dataOut", 32'(dataOut), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset carry", 32'(carry), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add f0+20",  3'b000, 8'hF0, 8'h20, 8'h00, 8'h10, 1'b0, 1'b1, 0, 1'b0);
    run_op("sub 5-5",    3'b100, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op("bnz pc41",   3'b010, 8'h00, 8'h77, 8'h41, 8'h42, 1'b0, 1'b0, 0, 1'b0);
    run_op("bnz pcff",   3'b010, 8'h00, 8'h77, 8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op("bnz taken",  3'b010, 8'h03, 8'h20, 8'h41, 8'h20, 1'b0, 1'b0, 0, 1'b0);
    run_op("sltu ff,01", 3'b011, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_op("slts ff,01", 3'b101, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run_op("nand f0,cc", 3'b001, 8'hF0, 8'hCC, 8'h00, 8'h3F, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub 3-5",    3'b100, 8'h03, 8'h05, 8'h00, 8'hFE, 1'b0, 1'b1, 0, 1'b0);
    run_op("mul 13*11",  3'b110, 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0, 1'b0, 8, 1'b1);
    run_op("add ff+01",  3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    run_op("shl 81<<9",  3'b111, 8'h81, 8'd9,  8'h00, 8'h02, 1'b0, 1'b0, 1, 1'b0);
    run_op("shl 81<<8",  3'b111, 8'h81, 8'd8,  8'h00, 8'h81, 1'b0, 1'b0, 0, 1'b0);

    // Abort a multiply while three iterations remain
    @(negedge clk);
    op = 3'b110; dataInACC = 8'd9; dataIn = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort dataOut", 32'(dataOut), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    check("abort carry", 32'(carry), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      dcount += int'(done);
    end
    check("abort no done", 32'(dcount), 32'd0);
    run_op("add 3+4",    3'b000, 8'h03, 8'h04, 8'h00, 8'h07, 1'b0, 1'b0, 0, 1'b0);

    // start held high: single-cycle ops complete every second cycle
    @(negedge clk);
    op = 3'b000; dataInACC = 8'h01; dataIn = 8'h02; start = 1'b1;
    pat = '0;
    repeat (8) begin
      @(negedge clk);
      pat = {pat[6:0], done};
    end
    start = 1'b0;
    check("held start pattern", 32'(pat), 32'hAA);
    repeat (3) @(negedge clk);
    check("held start dataOut", 32'(dataOut), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the accumulator ALU.
- Adds a start/done handshake, registered outputs and flags, and two iterative operations: multiply and logical shift-left.
- Sits between the accumulator/register operand bus and the writeback/PC-select mux; the control FSM issues `start` and waits for `done`.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- PC_WIDTH, 8, width of the pc input. Must be <= WIDTH; it is zero-extended when routed to dataOut.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  operation select, decoded at accept.
- dataInACC  input  WIDTH  operand A (accumulator).
- dataIn  input  WIDTH  operand B.
- pc  input  PC_WIDTH  current program counter (branch op only).
- dataOut  output  WIDTH  registered result; holds until the next done.
- zero  output  1  registered; 1 when the result just produced is all zeros.
- carry  output  1  registered; add carry-out or sub borrow; 0 for other ops.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle pulse marking a new dataOut/zero/carry.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; dataOut, zero, carry, busy and done all 0.
  - Internal counter and operand registers cleared.
  - Any in-flight op is abandoned, with no done.
- Op encoding:
  - 000 add: A+B, mod 2^WIDTH; carry = bit WIDTH.
  - 001 nand: ~(A&B).
  - 010 branch-not-zero: A==0 → pc+1, zero-extended (pc all-ones wraps to 0 in PC_WIDTH bits); else B.
  - 011 slt unsigned: 1 if A<B, else 0.
  - 100 sub: A-B, mod 2^WIDTH; carry=1 when borrow (A<B unsigned).
  - 101 slt signed: two's-complement compare; 1 if A<B.
  - 110 mul: low WIDTH bits of A*B, shift-add algorithm, one bit of B per cycle.
  - 111 shl: A shifted left by B mod WIDTH, one bit per cycle, zero fill.
- FSM states: IDLE, EXEC, DONE.
  - IDLE & start:
    - Latch op, A, B, pc.
    - Single-cycle ops (000–101): compute on that edge; go to DONE.
    - mul: acc=0, cnt=WIDTH; go to EXEC.
    - shl: cnt = B mod WIDTH. If cnt==0, result=A and go to DONE; else go to EXEC.
  - EXEC: each edge does one iteration and decrements cnt. On the edge where cnt goes 1→0, write the result and go to DONE.
  - DONE: done=1 and busy=1 for exactly this cycle; the next edge returns to IDLE unconditionally.
- Latency (start accepted at edge N):
  - Single-cycle ops and shl by 0: done high in the cycle after edge N.
  - mul: done after edge N+WIDTH.
  - shl by k: done after edge N+k.
- Handshake:
  - start is ignored while busy; no queueing.
  - start may be held high. A new op is accepted on the first edge back in IDLE, which is the edge after DONE, so back-to-back single-cycle ops give done every 2 cycles.
  - Inputs may change freely after accept; latched copies are used.
- Outputs:
  - dataOut, zero and carry update only on the edge entering DONE; otherwise they hold their value.
  - zero reflects the WIDTH-bit result.
  - Unknown/unused op codes: none, all 8 codes are defined.

Test Plan:
- Reset mid-mul: assert reset during EXEC (cnt=3) → outputs 0 immediately, state IDLE, no done pulse; a subsequent add 3+4 → dataOut=7.
- add 8'hF0+8'h20 → dataOut=8'h10, carry=1, zero=0, done one cycle after accept. Then sub 5-5 → dataOut=0, zero=1, carry=0.
- branch op:
  - A=0, pc=8'h41 → dataOut=8'h42.
  - A=0, pc=8'hFF → dataOut=8'h00, zero=1.
  - A=3, B=8'h20 → dataOut=8'h20.
- slt: A=8'hFF, B=8'h01 → unsigned op gives 0, signed op gives 1. nand 8'hF0,8'hCC → 8'h3F.
- mul 8'd13*8'd11 → dataOut=8'h8F (143), done exactly 8 cycles after accept. busy is high throughout. A start pulse issued while busy → no effect, no extra done.
- shl: A=8'h81, B=8'd9 → shift by 1 → dataOut=8'h02, done after 1 cycle. B=8'd8 → shift by 0 → dataOut=8'h81 with single-cycle latency. start held high continuously → done every 2 cycles for single-cycle ops.
